seq_mul_sched: RTL

//  Shares one W-bit shift-add sequential multiplier between two requesters.

---
 rtl/seq_mul_sched_pkg.sv | 18 +
 rtl/seq_mul_sched_if.sv | 34 +++
 rtl/seq_mul_sched_mul_dp.sv | 50 +++++
 rtl/seq_mul_sched.sv | 135 +++++++++++++
 4 files changed

// File: rtl/seq_mul_sched_pkg.sv
// Shared definitions for the shared shift-add multiplier scheduler:
// FSM state encoding, default operand width and a counter-width helper.
package seq_mul_sched_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter width; a 1-bit counter is kept for the degenerate W=1 case.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_mul_sched_if.sv
// Client-side bundle for the shared multiplier: two request/operand/ack
// channels plus the common result bus and busy flag.
interface seq_mul_sched_if
  import seq_mul_sched_pkg::*;
#(
  parameter int W = W_DEF
);

  logic           req0;
  logic [W-1:0]   a0;
  logic [W-1:0]   b0;
  logic           ack0;
  logic           req1;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic           ack1;
  logic [2*W-1:0] res;
  logic           res_vld;
  logic           res_id;
  logic           busy;

  // Client side drives requests and operands.
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  ack0, ack1, res, res_vld, res_id, busy
  );

  // Scheduler side answers with acks and results.
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output ack0, ack1, res, res_vld, res_id, busy
  );

endinterface

// File: rtl/seq_mul_sched_mul_dp.sv
// Shift-add multiplier datapath: multiplicand register A and the combined
// partial-product/multiplier register P. One add/shift per step. Assumes W >= 2.
module seq_mul_sched_mul_dp
  import seq_mul_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] prod_nxt_o
);

  logic [W-1:0] a_q;
  logic [2*W:0] p_q;
  logic [2*W:0] p_d;
  logic [2*W:0] p_step;
  logic [W:0]   sum;

  // One add/shift step and the load/step/hold selection for P.
  // p_q[2W] is always zero, so including it in the add does not change the sum.
  always_comb begin
    sum    = p_q[2*W:W] + {1'b0, (p_q[0] ? a_q : {W{1'b0}})};
    p_step = {1'b0, sum, p_q[W-1:1]};
    p_d    = p_q;
    if (load_i) begin
      p_d = {{(W+1){1'b0}}, b_i};
    end else if (step_i) begin
      p_d = p_step;
    end
  end

  // The product after the step in progress; on the last step this is final.
  assign prod_nxt_o = p_step[2*W-1:0];

  // Operand and partial-product registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      p_q <= '0;
    end else begin
      if (load_i) a_q <= a_i;
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/seq_mul_sched.sv
// Two-requester front end for one sequential multiplier: round-robin
// arbiter, sequencing FSM, step down-counter and ack/result registers.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting; on any request grant, load operands, pulse ack
//  ST_RUN  | one add/shift per cycle; counter hits 0 on the last step
//  ST_DONE | res/res_id updated, res_vld high for this one cycle
module seq_mul_sched
  import seq_mul_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_mul_sched_if.slave  bus
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             res_id_q, res_id_d;
  logic             res_vld_q, res_vld_d;

  logic             any_req;
  logic             gnt_id;
  logic             load;
  logic             step;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic [2*W-1:0]   prod_nxt;

  // Round-robin pick: a lone request wins; on a tie the one not served last wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    gnt_id  = bus.req1 & (~bus.req0 | ~last_q);
    a_sel   = gnt_id ? bus.a1 : bus.a0;
    b_sel   = gnt_id ? bus.b1 : bus.b0;
  end

  seq_mul_sched_mul_dp #(.W(W)) mul_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .a_i        (a_sel),
    .b_i        (b_sel),
    .prod_nxt_o (prod_nxt)
  );

  // Next-state, datapath control and output-register next values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    res_d     = res_q;
    res_id_d  = res_id_q;
    res_vld_d = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          load    = 1'b1;
          cnt_d   = CNT_INIT;
          owner_d = gnt_id;
          last_d  = gnt_id;
          ack0_d  = ~gnt_id;
          ack1_d  = gnt_id;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          res_d     = prod_nxt;
          res_id_d  = owner_q;
          res_vld_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and control registers; last grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      res_q     <= '0;
      res_id_q  <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      res_q     <= res_d;
      res_id_q  <= res_id_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.res     = res_q;
  assign bus.res_vld = res_vld_q;
  assign bus.res_id  = res_id_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule
